// File: rtl/mem_snapshot_pkg.sv
// rtl/mem_snapshot_pkg.sv - shared types and sizing helpers for mem_snapshot
// Contents:
//   state_e          controller states
//   calc_part_num    bus words per memory word
//   calc_part_bits   part-index width, never below 1
package mem_snapshot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MEM_WR = 2'd1,
      ST_MEM_RD = 2'd2,
      ST_ACK    = 2'd3
   } state_e;

   function automatic int calc_part_num(input int mem_width, input int bus_width);
      return mem_width / bus_width;
   endfunction

   // Bounded loop keeps this usable as a constant function during elaboration.
   function automatic int calc_part_bits(input int part_num);
      int bits;
      bits = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < part_num) bits = i + 1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/mem_snapshot_if.sv
// rtl/mem_snapshot_if.sv - upstream request and external memory signal bundle
// Upstream : req_vld, wr_en, rd_en, addr, wr_data -> ; <- rd_data, ack_vld
// Memory   : mem_req_vld, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data -> ;
//            <- mem_ack_vld, mem_rd_data
// slave modport is the snapshot controller, master is its environment.
interface mem_snapshot_if #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 128,
   parameter int MEM_ADDR_WIDTH = 1
);
   import mem_snapshot_pkg::*;

   localparam int PART_NUM      = calc_part_num(MEM_DATA_WIDTH, BUS_DATA_WIDTH);
   localparam int PART_BITS     = calc_part_bits(PART_NUM);
   localparam int UP_ADDR_WIDTH = MEM_ADDR_WIDTH + PART_BITS;

   logic                      req_vld;
   logic                      wr_en;
   logic                      rd_en;
   logic [UP_ADDR_WIDTH-1:0]  addr;
   logic [BUS_DATA_WIDTH-1:0] wr_data;
   logic [BUS_DATA_WIDTH-1:0] rd_data;
   logic                      ack_vld;

   logic                      mem_req_vld;
   logic                      mem_wr_en;
   logic                      mem_rd_en;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr;
   logic [MEM_DATA_WIDTH-1:0] mem_wr_data;
   logic                      mem_ack_vld;
   logic [MEM_DATA_WIDTH-1:0] mem_rd_data;

   modport slave (
      input  req_vld, wr_en, rd_en, addr, wr_data, mem_ack_vld, mem_rd_data,
      output rd_data, ack_vld, mem_req_vld, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
   );

   modport master (
      output req_vld, wr_en, rd_en, addr, wr_data, mem_ack_vld, mem_rd_data,
      input  rd_data, ack_vld, mem_req_vld, mem_wr_en, mem_rd_en, mem_addr, mem_wr_data
   );

endinterface

// File: rtl/mem_snapshot_snapshot_buf.sv
// rtl/mem_snapshot_snapshot_buf.sv - snapshot storage for parts 1..PART_NUM-1
// clk, rstn       clock, async active-low reset
// clr_i           synchronous clear to zero (highest priority)
// load_en_i       load all slots from load_data_i (memory read return)
// wr_en_i         write wr_data_i into slot wr_sel_i (slot 0 does not exist)
// data_o          all slots, slot p at [(p-1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH]
module snapshot_buf #(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int PART_NUM       = 4,
   parameter int PART_BITS      = 2
) (
   input  logic                                   clk,
   input  logic                                   rstn,
   input  logic                                   clr_i,
   input  logic                                   wr_en_i,
   input  logic [PART_BITS-1:0]                   wr_sel_i,
   input  logic [BUS_DATA_WIDTH-1:0]              wr_data_i,
   input  logic                                   load_en_i,
   input  logic [(PART_NUM-1)*BUS_DATA_WIDTH-1:0] load_data_i,
   output logic [(PART_NUM-1)*BUS_DATA_WIDTH-1:0] data_o
);

   localparam int BUF_WIDTH = (PART_NUM - 1) * BUS_DATA_WIDTH;

   logic [BUF_WIDTH-1:0] data_q;
   logic [BUF_WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (clr_i) begin
         data_d = '0;
      end else if (load_en_i) begin
         data_d = load_data_i;
      end else if (wr_en_i) begin
         for (int i = 1; i < PART_NUM; i++) begin
            if (wr_sel_i == PART_BITS'(i)) begin
               data_d[(i-1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = wr_data_i;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) data_q <= '0;
      else       data_q <= data_d;
   end

   assign data_o = data_q;

endmodule

// File: rtl/mem_snapshot.sv
// rtl/mem_snapshot.sv - narrow-bus to wide-memory adapter with a part snapshot buffer
// clk       sole clock
// rstn      async active-low reset
// soft_rst  sync active-high reset, aborts any operation without an ack
// bus       mem_snapshot_if.slave: upstream request/ack and memory request/ack
// Parts 1..N-1 are staged in / served from the snapshot buffer; part 0
// triggers the full-width memory write or read.
module mem_snapshot
   import mem_snapshot_pkg::*;
#(
   parameter int BUS_DATA_WIDTH = 32,
   parameter int MEM_DATA_WIDTH = 128,
   parameter int MEM_ADDR_WIDTH = 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            soft_rst,
   mem_snapshot_if.slave   bus
);

   localparam int PART_NUM      = calc_part_num(MEM_DATA_WIDTH, BUS_DATA_WIDTH);
   localparam int PART_BITS     = calc_part_bits(PART_NUM);
   localparam int UP_ADDR_WIDTH = MEM_ADDR_WIDTH + PART_BITS;
   localparam int BUF_WIDTH     = (PART_NUM - 1) * BUS_DATA_WIDTH;

   state_e                    state_q, state_d;
   logic [BUS_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
   logic                      mem_req_vld_q, mem_req_vld_d;
   logic                      mem_wr_en_q, mem_wr_en_d;
   logic                      mem_rd_en_q, mem_rd_en_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [MEM_DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;

   logic                      buf_clr;
   logic                      buf_wr_en;
   logic                      buf_load_en;
   logic [BUF_WIDTH-1:0]      buf_data;
   logic [BUS_DATA_WIDTH-1:0] buf_slot;

   logic [PART_BITS-1:0]      part;
   logic [MEM_ADDR_WIDTH-1:0] entry;
   logic                      wr_req;
   logic                      rd_req;

   assign part   = bus.addr[PART_BITS-1:0];
   assign entry  = bus.addr[UP_ADDR_WIDTH-1:PART_BITS];
   // Exactly one of wr_en/rd_en makes a real request; anything else is a no-op ack.
   assign wr_req = bus.wr_en & ~bus.rd_en;
   assign rd_req = bus.rd_en & ~bus.wr_en;

   snapshot_buf #(
      .BUS_DATA_WIDTH (BUS_DATA_WIDTH),
      .PART_NUM       (PART_NUM),
      .PART_BITS      (PART_BITS)
   ) u_buf (
      .clk         (clk),
      .rstn        (rstn),
      .clr_i       (buf_clr),
      .wr_en_i     (buf_wr_en),
      .wr_sel_i    (part),
      .wr_data_i   (bus.wr_data),
      .load_en_i   (buf_load_en),
      .load_data_i (bus.mem_rd_data[MEM_DATA_WIDTH-1:BUS_DATA_WIDTH]),
      .data_o      (buf_data)
   );

   always_comb begin
      buf_slot = '0;
      for (int i = 1; i < PART_NUM; i++) begin
         if (part == PART_BITS'(i)) buf_slot = buf_data[(i-1)*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
      end
   end

   // Memory-side outputs and rd_data default to zero every cycle, so each is a
   // single-cycle pulse. mem_req_vld is only raised from IDLE and IDLE is
   // never the next state, so it cannot repeat on consecutive cycles.
   always_comb begin
      state_d       = state_q;
      rd_data_d     = '0;
      mem_req_vld_d = 1'b0;
      mem_wr_en_d   = 1'b0;
      mem_rd_en_d   = 1'b0;
      mem_addr_d    = '0;
      mem_wr_data_d = '0;
      buf_clr       = 1'b0;
      buf_wr_en     = 1'b0;
      buf_load_en   = 1'b0;

      if (soft_rst) begin
         state_d = ST_IDLE;
         buf_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_vld) begin
                  state_d = ST_ACK;
                  if (wr_req) begin
                     if (part == '0) begin
                        mem_req_vld_d = 1'b1;
                        mem_wr_en_d   = 1'b1;
                        mem_addr_d    = entry;
                        mem_wr_data_d = {buf_data, bus.wr_data};
                        state_d       = ST_MEM_WR;
                     end else begin
                        buf_wr_en = 1'b1;
                     end
                  end else if (rd_req) begin
                     if (part == '0) begin
                        mem_req_vld_d = 1'b1;
                        mem_rd_en_d   = 1'b1;
                        mem_addr_d    = entry;
                        state_d       = ST_MEM_RD;
                     end else begin
                        rd_data_d = buf_slot;
                     end
                  end
               end
            end
            ST_MEM_WR: begin
               if (bus.mem_ack_vld) state_d = ST_ACK;
            end
            ST_MEM_RD: begin
               if (bus.mem_ack_vld) begin
                  buf_load_en = 1'b1;
                  rd_data_d   = bus.mem_rd_data[BUS_DATA_WIDTH-1:0];
                  state_d     = ST_ACK;
               end
            end
            ST_ACK: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         rd_data_q     <= '0;
         mem_req_vld_q <= 1'b0;
         mem_wr_en_q   <= 1'b0;
         mem_rd_en_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
      end else begin
         state_q       <= state_d;
         rd_data_q     <= rd_data_d;
         mem_req_vld_q <= mem_req_vld_d;
         mem_wr_en_q   <= mem_wr_en_d;
         mem_rd_en_q   <= mem_rd_en_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
      end
   end

   assign bus.ack_vld     = (state_q == ST_ACK);
   assign bus.rd_data     = rd_data_q;
   assign bus.mem_req_vld = mem_req_vld_q;
   assign bus.mem_wr_en   = mem_wr_en_q;
   assign bus.mem_rd_en   = mem_rd_en_q;
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_data = mem_wr_data_q;

endmodule
